commit_step_queue: RTL

Elastic buffer between the core's dual-wide commit trace and the single-wide `ArchStepBB` co-simulation sink. It accepts up to two retired instructions per cycle, in program order, and stores them in a FIFO. It presents at most one instruction per cycle on a registered output that drives `ArchStepBB` `valid`/`pc`/`inst` directly. The sink has no backpressure and the core cannot be stalled by trace logic, so entries are dropped on overflow and counted.

---
 rtl/commit_step_queue_if.sv | 26 ++
 rtl/commit_step_queue.sv | 109 ++++++++++
 2 files changed

// File: rtl/commit_step_queue_if.sv
// Commit-trace bundle between the dual-wide retire port, the queue and the single-wide step sink.
interface commit_step_queue_if;
  logic        in0_valid;
  logic [63:0] in0_pc;
  logic [31:0] in0_inst;
  logic        in1_valid;
  logic [63:0] in1_pc;
  logic [31:0] in1_inst;
  logic        out_stall;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        overflow;
  logic [15:0] drop_count;

  modport master (
    output in0_valid, in0_pc, in0_inst, in1_valid, in1_pc, in1_inst, out_stall,
    input  in_ready, out_valid, out_pc, out_inst, overflow, drop_count
  );

  modport slave (
    input  in0_valid, in0_pc, in0_inst, in1_valid, in1_pc, in1_inst, out_stall,
    output in_ready, out_valid, out_pc, out_inst, overflow, drop_count
  );
endinterface

// File: rtl/commit_step_queue.sv
// Dual-in/single-out retire trace FIFO; push-to-output 2 cycles; no input backpressure, excess dropped and counted.
// COMMIT_STEP_QUEUE_DROP_COUNT_EN enables the 16-bit saturating drop counter (otherwise drop_count is 0).
module commit_step_queue #(
  parameter int DEPTH = 8
) (
  input logic              clock,
  input logic              reset,
  commit_step_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [63:0]   r_out_pc;
  logic [31:0]   r_out_inst;
  logic          r_overflow;

  logic [CW-1:0] w_free;
  logic [1:0]    w_nvalid;
  logic [1:0]    w_acc;
  logic [1:0]    w_drop;
  logic          w_pop;
  logic [AW-1:0] w_tail1;
  logic [63:0]   w_wr0_pc;
  logic [31:0]   w_wr0_inst;

  // Free space is taken from the start-of-cycle count; a same-cycle pop frees nothing.
  assign w_free   = CW'(DEPTH) - r_count;
  assign w_nvalid = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid};
  assign w_pop    = (r_count != '0) && !bus.out_stall;
  assign w_tail1  = r_tail + AW'(1);

  always_comb begin
    w_acc = w_nvalid;
    if (w_free == '0)
      w_acc = 2'd0;
    else if ((w_free == CW'(1)) && (w_nvalid == 2'd2))
      w_acc = 2'd1;
  end

  assign w_drop     = w_nvalid - w_acc;
  assign w_wr0_pc   = bus.in0_valid ? bus.in0_pc   : bus.in1_pc;
  assign w_wr0_inst = bus.in0_valid ? bus.in0_inst : bus.in1_inst;

  // The second write slot is only ever in1, since acceptance is in age order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_acc != 2'd0) begin
        r_mem_pc[r_tail]   <= w_wr0_pc;
        r_mem_inst[r_tail] <= w_wr0_inst;
      end
      if (w_acc == 2'd2) begin
        r_mem_pc[w_tail1]   <= bus.in1_pc;
        r_mem_inst[w_tail1] <= bus.in1_inst;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_head      <= r_head + AW'(w_pop);
      r_tail      <= r_tail + AW'(w_acc);
      r_count     <= r_count + CW'(w_acc) - CW'(w_pop);
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_pc   <= r_mem_pc[r_head];
        r_out_inst <= r_mem_inst[r_head];
      end
      r_overflow  <= r_overflow | (w_drop != 2'd0);
    end
  end

  assign bus.in_ready  = (w_free >= CW'(2));
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_inst  = r_out_inst;
  assign bus.overflow  = r_overflow;

`ifdef COMMIT_STEP_QUEUE_DROP_COUNT_EN
  logic [15:0] r_drop_count;
  logic [16:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop);

  always_ff @(posedge clock) begin
    if (reset)
      r_drop_count <= '0;
    else
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign bus.drop_count = r_drop_count;
`else
  assign bus.drop_count = 16'd0;
`endif
endmodule
